// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file's single write port between requester A (ALU) and requester B (load).
// Latency: an entry accepted at edge N drives we during cycle N..N+1 and commits at edge N+1 if it is not blocked.
// Backpressure: x_ready = !flush && (buffer empty || buffer granted this cycle); one write per cycle in total.
// Optional feature: define WB_SCOREBOARD_EN to get busy1/busy2 pending-write lookup; otherwise both busy outputs are 0.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2
);

  // One-entry holding buffers. seq = 1 marks the younger of two buffered entries.
  logic              buf_a_valid;
  logic [ADDR_W-1:0] buf_a_addr;
  logic [DATA_W-1:0] buf_a_data;
  logic              buf_a_seq;
  logic              buf_b_valid;
  logic [ADDR_W-1:0] buf_b_addr;
  logic [DATA_W-1:0] buf_b_data;
  logic              buf_b_seq;
  // Round-robin pointer: 0 prefers A, 1 prefers B.
  logic              rr_ptr;

  logic both_valid;
  logic same_addr;
  logic a_older;
  logic grant_a;
  logic grant_b;
  logic accept_a;
  logic accept_b;
  logic load_a;
  logic load_b;

  assign both_valid = buf_a_valid && buf_b_valid;
  assign same_addr  = (buf_a_addr == buf_b_addr);
  // A is older when it was not marked younger, or when B carries the younger mark.
  assign a_older    = !buf_a_seq || buf_b_seq;

  // Grant selection from buffer contents only; never looks at the incoming handshakes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (both_valid) begin
      if (same_addr) begin
        // Same destination: the older value goes first so the younger one lands last.
        grant_a = a_older;
        grant_b = !a_older;
      end else begin
        grant_a = !rr_ptr;
        grant_b = rr_ptr;
      end
    end else begin
      grant_a = buf_a_valid;
      grant_b = buf_b_valid;
    end
  end

  // Ready depends only on flush and buffer/grant state, never on the requester's valid.
  assign a_ready  = !flush && (!buf_a_valid || grant_a);
  assign b_ready  = !flush && (!buf_b_valid || grant_b);

  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;
  // Writes to x0 are accepted but never buffered, so they can never raise we.
  assign load_a   = accept_a && (a_addr != '0);
  assign load_b   = accept_b && (b_addr != '0);

  // Write port mux; an idle port presents zero address and data.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (grant_a) begin
      we    = 1'b1;
      waddr = buf_a_addr;
      wdata = buf_a_data;
    end else if (grant_b) begin
      we    = 1'b1;
      waddr = buf_b_addr;
      wdata = buf_b_data;
    end
  end

  // Buffer A: load on accept (replacing a granted entry), clear on grant or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_a_valid <= 1'b0;
      buf_a_addr  <= '0;
      buf_a_data  <= '0;
    end else if (flush) begin
      buf_a_valid <= 1'b0;
    end else if (accept_a) begin
      buf_a_valid <= load_a;
      buf_a_addr  <= a_addr;
      buf_a_data  <= a_data;
    end else if (grant_a) begin
      buf_a_valid <= 1'b0;
    end
  end

  // Buffer B: load on accept (replacing a granted entry), clear on grant or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_b_valid <= 1'b0;
      buf_b_addr  <= '0;
      buf_b_data  <= '0;
    end else if (flush) begin
      buf_b_valid <= 1'b0;
    end else if (accept_b) begin
      buf_b_valid <= load_b;
      buf_b_addr  <= b_addr;
      buf_b_data  <= b_data;
    end else if (grant_b) begin
      buf_b_valid <= 1'b0;
    end
  end

  // Age tracking: the most recent load is younger; a same-edge pair treats A as older.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_a_seq <= 1'b0;
      buf_b_seq <= 1'b0;
    end else if (flush) begin
      buf_a_seq <= 1'b0;
      buf_b_seq <= 1'b0;
    end else if (load_b) begin
      buf_a_seq <= 1'b0;
      buf_b_seq <= 1'b1;
    end else if (load_a) begin
      buf_a_seq <= 1'b1;
      buf_b_seq <= 1'b0;
    end
  end

  // Round-robin pointer moves only on a true contention decision and points at the loser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (flush) begin
      rr_ptr <= 1'b0;
    end else if (both_valid && !same_addr) begin
      rr_ptr <= grant_a;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // A read port is busy when either buffer holds a pending write to that nonzero register.
  assign busy1 = (raddr1 != '0) &&
                 ((buf_a_valid && (buf_a_addr == raddr1)) ||
                  (buf_b_valid && (buf_b_addr == raddr1)));
  assign busy2 = (raddr2 != '0) &&
                 ((buf_a_valid && (buf_a_addr == raddr2)) ||
                  (buf_b_valid && (buf_b_addr == raddr2)));
`else
  // Lookup removed: read addresses are intentionally ignored.
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: expected writes are queued when stimulus is driven and
// popped in order whenever the write port fires; handshake and busy outputs are checked mid-cycle.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          busy1;
  logic          busy2;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  logic [DW-1:0]    rf [32];

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    exp_q.push_back({ad, d});
  endtask

  // Write-port monitor: every we pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("waddr", 32'(waddr), 32'(mon_e[DW+:AW]));
        chk("wdata", wdata, mon_e[DW-1:0]);
        rf[waddr] = wdata;
      end
    end
  end

  initial begin
    int ia;
    int ib;
    logic ea;
    logic eb;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; flush = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    raddr1 = '0; raddr2 = '0;
    #1 rst = 1'b0;
    #1;
    // Reset state
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    flush = 1'b1;
    #1;
    chk("rst_flush_a_ready", 32'(a_ready), 32'd0);
    chk("rst_flush_b_ready", 32'(b_ready), 32'd0);
    flush = 1'b0;
    tick(); tick();
    rst = 1'b1;
    mid();
    chk("post_rst_we", 32'(we), 32'd0);

    // Single A stream: x5 then x6 on consecutive cycles
    tick();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11; push(5'd5, 32'h11);
    mid(); chk("s_a_ready0", 32'(a_ready), 32'd1);
    tick();
    a_addr = 5'd6; a_data = 32'h22; push(5'd6, 32'h22);
    mid(); chk("s_a_ready1", 32'(a_ready), 32'd1);
    chk("s_we1", 32'(we), 32'd1);
    tick();
    a_valid = 1'b0;
    mid(); chk("s_a_ready2", 32'(a_ready), 32'd1);
    chk("s_we2", 32'(we), 32'd1);
    tick();
    mid(); chk("s_we_idle", 32'(we), 32'd0);

    // Contention: A on x1, B on x2, both valid every cycle; grants alternate from A
    ia = 0; ib = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h100 + 32'(ia);
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h200 + 32'(ib);
      ea = (k == 0) || (k % 2 == 1);
      eb = (k == 0) || (k % 2 == 0);
      mid();
      chk("c_a_ready", 32'(a_ready), 32'(ea));
      chk("c_b_ready", 32'(b_ready), 32'(eb));
      if (ea) begin push(5'd1, 32'h100 + 32'(ia)); ia++; end
      if (eb) begin push(5'd2, 32'h200 + 32'(ib)); ib++; end
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
    mid(); chk("c_we_idle", 32'(we), 32'd0);

    // Same address accepted together: A first, B survives
    tick();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB;
    push(5'd7, 32'hAAAA); push(5'd7, 32'hBBBB);
    mid(); chk("sa_a_ready", 32'(a_ready), 32'd1); chk("sa_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    mid(); chk("sa_a_ready1", 32'(a_ready), 32'd1); chk("sa_b_ready1", 32'(b_ready), 32'd0);
    tick(); mid();
    tick(); mid();
    chk("sa_we_idle", 32'(we), 32'd0);
    chk("sa_x7", rf[7], 32'hBBBB);

    // Same address, B one cycle earlier: B written first, A's value survives
    tick();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h1111; push(5'd7, 32'h1111);
    mid();
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h2222; push(5'd7, 32'h2222);
    mid(); chk("sb_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    mid();
    tick(); mid();
    chk("sb_x7", rf[7], 32'h2222);
    chk("sb_we_idle", 32'(we), 32'd0);

    // x0 write is accepted and dropped
    tick();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD;
    mid(); chk("x0_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    mid();
    chk("x0_we", 32'(we), 32'd0);
    chk("x0_busy1", 32'(busy1), 32'd0);
    chk("x0_b_ready1", 32'(b_ready), 32'd1);
    tick(); mid(); chk("x0_we2", 32'(we), 32'd0);

    // Flush with both buffers full: presented write (A) completes, B is dropped
    tick();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    push(5'd3, 32'h33);
    mid();
    tick();
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b1;
    mid();
    chk("fl_a_ready", 32'(a_ready), 32'd0);
    chk("fl_b_ready", 32'(b_ready), 32'd0);
    chk("fl_we", 32'(we), 32'd1);
    tick();
    flush = 1'b0;
    mid();
    chk("fl_we_after", 32'(we), 32'd0);
    chk("fl_a_ready_after", 32'(a_ready), 32'd1);
    chk("fl_b_ready_after", 32'(b_ready), 32'd1);

    // Reset mid-stream: we drops at once and nothing is written afterwards
    tick();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBB;
    mid();
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mr_we", 32'(we), 32'd0);
    chk("mr_waddr", 32'(waddr), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    mid();
    chk("mr_we_after", 32'(we), 32'd0);
    chk("mr_x10", rf[10], 32'd0);
    chk("mr_x11", rf[11], 32'd0);

    // Scoreboard lookup on x9
    tick();
    raddr1 = 5'd9; raddr2 = 5'd0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99; push(5'd9, 32'h99);
    mid(); chk("sc_busy1_pre", 32'(busy1), 32'd0);
    tick();
    a_valid = 1'b0;
    mid();
    chk("sc_busy1", 32'(busy1), 32'(SB));
    chk("sc_busy2", 32'(busy2), 32'd0);
    tick();
    mid();
    chk("sc_busy1_post", 32'(busy1), 32'd0);
    chk("sc_we_idle", 32'(we), 32'd0);

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32x32 integer register file. It shares the register file's single write port between two writeback requesters: A (ALU/execute result) and B (load/memory result). Each requester gets a one-entry holding buffer. The block grants at most one write per cycle using round-robin with same-address ordering protection. It sits between the writeback stages and the register file's `we/waddr/wdata` inputs.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers)

Ports:
- `clk` in 1: the block's one clock; all state updates on the rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `flush` in 1: synchronous; drops all buffered, unwritten entries
- `a_valid` in 1, `a_ready` out 1, `a_addr` in ADDR_W, `a_data` in DATA_W: requester A handshake
- `b_valid` in 1, `b_ready` out 1, `b_addr` in ADDR_W, `b_data` in DATA_W: requester B handshake
- `we` out 1, `waddr` out ADDR_W, `wdata` out DATA_W: to the register file write port
- `raddr1` in ADDR_W, `raddr2` in ADDR_W: register file read addresses (scoreboard lookup)
- `busy1` out 1, `busy2` out 1: a pending write targets `raddr1` / `raddr2`

## Operation
- State:
  - per-requester buffer: `valid`, `addr`, `data`, plus a `seq` age bit;
  - `rr_ptr` (0 = A preferred, 1 = B preferred).
- Accept (handshake):
  - X is accepted at an edge when `x_valid && x_ready`; the buffer loads `addr`/`data`.
  - `x_ready = !flush && (!bufX.valid || grantX)`. The ready equation is combinational; `x_ready` must not depend on `x_valid`.
- Address 0:
  - an accepted request with `addr == 0` is accepted and discarded;
  - the buffer stays or becomes empty, and `we` is never raised for it.
- Grant (combinational, from buffers only):
  - only A valid → A; only B valid → B.
  - both valid, addresses differ → side selected by `rr_ptr`.
  - both valid, same address → the older entry (per `seq`), so the younger value lands last.
  - A and B accepted in the same cycle with the same address → A is treated as older, so B's value survives.
- Output:
  - `we = grantA | grantB`; `waddr`/`wdata` are muxed from the granted buffer;
  - `we = 0` gives `waddr = 0`, `wdata = 0`.
- The granted buffer clears at the edge. `rr_ptr` updates only on a round-robin decision (both valid, different addresses) and points to the non-granted side.
- Flush:
  - both buffers clear at the edge; `seq` and `rr_ptr` reset;
  - `we` is still driven from the current buffers during the flush cycle, so the write already presented completes.

## Timing
- Reset (asynchronous assert, synchronous release): buffers empty, `rr_ptr = 0`, `seq = 0`.
- Outputs during reset: `we = 0`, `waddr = 0`, `wdata = 0`, `a_ready = b_ready = 1`, `busy1 = busy2 = 0`.
  - Exception: while `flush` is held during reset, `a_ready = b_ready = 0`.
- Latency: accepted at edge N → `we` high during cycle N..N+1 → the register file commits at edge N+1 (1 cycle), if not blocked.
- Throughput:
  - 1 write/cycle total;
  - a sole active requester sustains 1/cycle;
  - two requesters alternate, and each sees `ready` low every other cycle.
- Worst-case wait for a buffered entry: 1 cycle (round-robin fairness).
- Reset mid-operation: buffered entries are lost with no partial write; `we` drops asynchronously.
- A simultaneous accept and grant on the same side at one edge is legal: the buffer is replaced with the new entry.

## Configuration
- `WB_SCOREBOARD_EN` defined:
  - `busyN = (bufA.valid && bufA.addr == raddrN) || (bufB.valid && bufB.addr == raddrN)`, for nonzero `raddrN` only;
  - purely combinational from buffer state;
  - the decode stage stalls on busy.
- Undefined: the scoreboard logic is removed and `busy1 = busy2 = 0` constantly. The port list is unchanged.

## Test plan
- Single A stream: A writes x5=0x11 at edge 0, x6=0x22 at edge 1 → `we` high 2 consecutive cycles; the x5, then x6, values appear on `waddr`/`wdata`; `a_ready` stays 1.
- Contention: A and B both valid every cycle on different addresses (x1/x2) → grants alternate A, B, A, B starting with A after reset; `ready` toggles accordingly, with no lost or duplicated write.
- Same-address ordering:
  - A x7=0xAAAA and B x7=0xBBBB accepted in the same cycle → writes in order A then B; final x7 = 0xBBBB.
  - B accepted one cycle earlier → B is written first.
- x0 drop: B writes x0=0xDEAD → accepted (`b_ready` = 1), `we` never high, `busy` never set.
- Flush/reset: both buffers full, assert `flush` → the presented write completes, the other is dropped, both `ready` low that cycle. Then pull `rst` low mid-stream → `we = 0` immediately, and no write after release.
- Scoreboard (`WB_SCOREBOARD_EN`):
  - A buffered to x9, `raddr1 = 9` → `busy1 = 1` until the commit edge, then 0.
  - `raddr2 = 0` → `busy2 = 0`.
  - Without the macro → both busy outputs 0 throughout.
